// File: rtl/mips_cpu_state_controller.sv
// Multi-cycle sequencer for the MIPS core: fetch/decode/exec/mem/writeback,
// memory stall handling, retired-instruction count and halt after a jump-to-0 delay slot.
//
// state     | meaning
// FETCH     | read instruction at PC, load IR when memory answers
// DECODE    | instruction register settles, no strobes
// EXEC      | ALU/branch/jump resolve, pick MEM or WRITEBACK
// MEM       | data read (load) or write (store) at ALU address
// WRITEBACK | register write for regwr class, retire
// HALTED    | absorbing, left only by reset
module mips_cpu_state_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_waitrequest,
  input  logic             i_target_is_zero,
  output logic [2:0]       o_state,
  output logic             o_ir_enable,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_addr_sel_data,
  output logic             o_reg_write,
  output logic             o_pc_write,
  output logic             o_active,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_halt_pending;
  logic             r_delay_slot;
  logic             w_halt_pending_nxt;
  logic             w_delay_slot_nxt;
  logic [CNT_W-1:0] r_retired;

  logic w_is_rtype;
  logic w_is_load;
  logic w_is_store;
  logic w_is_jump;
  logic w_is_regwr;

  // Branches need no class signal: they take the WRITEBACK path without a register write.
  always_comb begin
    w_is_rtype = (i_opcode == 6'h00);
    w_is_load  = (i_opcode >= 6'h20) && (i_opcode <= 6'h26);
    w_is_store = (i_opcode == 6'h28) || (i_opcode == 6'h29) || (i_opcode == 6'h2B);
    w_is_jump  = (i_opcode == 6'h02) || (i_opcode == 6'h03) ||
                 (w_is_rtype && ((i_funct == 6'h08) || (i_funct == 6'h09)));
    w_is_regwr = (w_is_rtype && (i_funct != 6'h08)) || w_is_load ||
                 (i_opcode == 6'h03) || (i_opcode[5:3] == 3'b001);
  end

  always_comb begin
    w_next             = r_state;
    w_halt_pending_nxt = r_halt_pending;
    w_delay_slot_nxt   = r_delay_slot;
    o_ir_enable        = 1'b0;
    o_mem_read         = 1'b0;
    o_mem_write        = 1'b0;
    o_addr_sel_data    = 1'b0;
    o_reg_write        = 1'b0;
    o_pc_write         = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        o_mem_read = 1'b1;
        if (!i_waitrequest) begin
          o_ir_enable = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        // A flag raised by an earlier jump marks this instruction as its delay slot.
        w_delay_slot_nxt = r_halt_pending;
        if (w_is_jump && i_target_is_zero) w_halt_pending_nxt = 1'b1;
        w_next = (w_is_load || w_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        o_addr_sel_data = 1'b1;
        o_mem_read      = w_is_load;
        o_mem_write     = w_is_store && !w_is_load;
        if (!i_waitrequest) begin
          if (w_is_store) o_pc_write = 1'b1;
          else            w_next     = S_WB;
        end
      end
      S_WB: begin
        o_reg_write = w_is_regwr;
        o_pc_write  = 1'b1;
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_FETCH;
    endcase
    if (o_pc_write) begin
      if (r_delay_slot) begin
        w_next             = S_HALTED;
        w_halt_pending_nxt = 1'b0;
        w_delay_slot_nxt   = 1'b0;
      end else begin
        w_next = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_FETCH;
      r_halt_pending <= 1'b0;
      r_delay_slot   <= 1'b0;
      r_retired      <= '0;
    end else begin
      r_state        <= w_next;
      r_halt_pending <= w_halt_pending_nxt;
      r_delay_slot   <= w_delay_slot_nxt;
      if (o_pc_write) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_state   = r_state;
  assign o_active  = (r_state != S_HALTED);
  assign o_retired = r_retired;

endmodule
